// File: rtl/uart_mmio_regs_pkg.sv
// uart_mmio_regs_pkg: register offsets, CON bit positions and address decode
package uart_mmio_regs_pkg;
  localparam logic [31:0] OFF_TXD = 32'd0;
  localparam logic [31:0] OFF_RXD = 32'd4;
  localparam logic [31:0] OFF_CON = 32'd8;
  localparam int CON_TXIE   = 0;
  localparam int CON_RXIE   = 1;
  localparam int CON_TXDONE = 2;
  localparam int CON_RXNE   = 3;
  localparam int CON_TXBUSY = 4;
  localparam int CON_TXOVF  = 5;
  localparam int CON_RXOVF  = 6;
  typedef enum logic [1:0] {SEL_NONE, SEL_TXD, SEL_RXD, SEL_CON} reg_sel_e;
  function automatic reg_sel_e reg_decode(input logic [31:0] addr, input logic [31:0] base);
    return addr == base + OFF_TXD ? SEL_TXD :
           addr == base + OFF_RXD ? SEL_RXD :
           addr == base + OFF_CON ? SEL_CON : SEL_NONE;
  endfunction
endpackage

// File: rtl/uart_mmio_regs_if.sv
// uart_mmio_regs_if: CPU data-memory bus for the UART register window
interface uart_mmio_regs_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_wr;
  logic        mem_rd;
  modport master(output addr, wdata, mem_wr, mem_rd, input rdata);
  modport slave(input addr, wdata, mem_wr, mem_rd, output rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO for received data; push while full is accepted only alongside a pop
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rptr];
  // an empty pop is ignored; a full push goes through only when a pop frees the slot
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end
  // storage array, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_mmio_regs.sv
// uart_mmio_regs: CPU register front-end for the UART (TX handshake, RX FIFO, CON flags, irq)
module uart_mmio_regs
  import uart_mmio_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0018,
  parameter int          RX_DEPTH    = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  uart_mmio_regs_if.slave   bus,
  output logic              irq,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic [1:0]        uart_signal,
  input  logic [7:0]        rx_data
);
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] sync_prev;
  logic sync_rx, sync_tx, rx_rise, tx_fall;
  logic txie, rxie, txdone, txovf, rxovf;
  logic wr, rd, tx_busy, rxne, pop, full, empty;
  logic [7:0] dout;
  logic [$clog2(RX_DEPTH):0] count;
  logic [31:0] con;
  reg_sel_e sel;
  assign sync_rx = sync_q[SYNC_STAGES-1][0];
  assign sync_tx = sync_q[SYNC_STAGES-1][1];
  // decode, handshake status and CON view
  always_comb begin
    sel     = reg_decode(bus.addr, BASE_ADDR);
    wr      = bus.mem_wr & ~bus.mem_rd;
    rd      = bus.mem_rd & ~bus.mem_wr;
    rx_rise = sync_rx & ~sync_prev[0];
    tx_fall = ~sync_tx & sync_prev[1];
    tx_busy = tx_en | sync_tx;
    rxne    = ~empty;
    pop     = rd & (sel == SEL_RXD);
    con     = {25'b0, rxovf, txovf, tx_busy, rxne, txdone, rxie, txie};
    bus.rdata = sel == SEL_TXD ? {24'b0, tx_data} :
                sel == SEL_RXD ? {24'b0, empty ? 8'h00 : dout} :
                sel == SEL_CON ? con : 32'b0;
  end
  // bring UART status into the clk domain and keep last value for edge detection
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= uart_signal;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  // register writes, TX request handshake and sticky flags; set events are last so they beat w1c
  always_ff @(posedge clk)
    if (reset) begin
      tx_data <= '0;
      tx_en   <= 1'b0;
      irq     <= 1'b0;
      txie    <= 1'b0;
      rxie    <= 1'b0;
      txdone  <= 1'b0;
      txovf   <= 1'b0;
      rxovf   <= 1'b0;
    end else begin
      if (wr && sel == SEL_CON) begin
        txie <= bus.wdata[CON_TXIE];
        rxie <= bus.wdata[CON_RXIE];
        if (bus.wdata[CON_TXDONE]) txdone <= 1'b0;
        if (bus.wdata[CON_TXOVF]) txovf <= 1'b0;
        if (bus.wdata[CON_RXOVF]) rxovf <= 1'b0;
      end
      if (wr && sel == SEL_TXD && tx_busy) txovf <= 1'b1;
      if (wr && sel == SEL_TXD && !tx_busy) begin
        tx_data <= bus.wdata[7:0];
        tx_en   <= 1'b1;
      end
      if (tx_en && sync_tx) tx_en <= 1'b0;
      if (tx_fall) txdone <= 1'b1;
      if (rx_rise && full && !pop) rxovf <= 1'b1;
      irq <= (txie & txdone) | (rxie & rxne);
    end
  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_rise),
    .pop   (pop),
    .din   (rx_data),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_uart_mmio_regs.sv
// tb_uart_mmio_regs: directed scenarios plus randomized ops against a queue/flag reference model
module tb_uart_mmio_regs;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] TXD = BASE, RXD = BASE + 4, CON = BASE + 8;
  logic clk = 0, reset = 1, irq, tx_en;
  logic [7:0] tx_data, rx_data = 0;
  logic [1:0] uart_signal = 0;
  logic [31:0] d;
  int checks = 0, errors = 0;
  uart_mmio_regs_if bus();
  uart_mmio_regs dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq), .tx_data(tx_data), .tx_en(tx_en),
    .uart_signal(uart_signal), .rx_data(rx_data)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] w);
    bus.addr = a; bus.wdata = w; bus.mem_wr = 1; tick; bus.mem_wr = 0;
  endtask
  task automatic load(input logic [31:0] a, output logic [31:0] r);
    bus.addr = a; bus.mem_rd = 1; #1 r = bus.rdata; tick; bus.mem_rd = 0;
  endtask
  task automatic tx_handshake;
    uart_signal[1] = 1; repeat (3) tick; uart_signal[1] = 0; repeat (4) tick;
  endtask
  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; uart_signal[0] = 1; repeat (4) tick; uart_signal[0] = 0; repeat (3) tick;
  endtask

  task automatic test_reset;
    reset = 1; repeat (2) tick; reset = 0;
    load(CON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_con got %h exp 0", d); end
    checks++; if (tx_en !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_out tx_en %b irq %b exp 0 0", tx_en, irq); end
  endtask

  task automatic test_tx;
    store(TXD, 32'h41);
    checks++; if (tx_data !== 8'h41 || tx_en !== 1'b1) begin errors++; $display("FAIL tx_start tx_data %h tx_en %b exp 41 1", tx_data, tx_en); end
    uart_signal[1] = 1; repeat (2) tick;
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL tx_hold tx_en %b exp 1", tx_en); end
    tick;
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL tx_ack tx_en %b exp 0", tx_en); end
    load(CON, d);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL tx_busy_con got %h exp 10", d); end
    uart_signal[1] = 0; repeat (3) tick;
    load(CON, d);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL tx_done_con got %h exp 04", d); end
  endtask

  task automatic test_irq;
    store(CON, 32'h5); tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
    store(TXD, 32'h42); tx_handshake;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_txdone got %b exp 1", irq); end
    store(CON, 32'h5);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_latency got %b exp 1", irq); end
    tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    load(CON, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL irq_con got %h exp 01", d); end
  endtask

  task automatic test_rx_overflow;
    for (int b = 'h10; b <= 'h14; b++) rx_byte(8'(b));
    load(CON, d);
    checks++; if (d !== 32'h49) begin errors++; $display("FAIL rxovf_con got %h exp 49", d); end
    for (int i = 0; i < 4; i++) begin
      load(RXD, d);
      checks++; if (d !== 32'h10 + i) begin errors++; $display("FAIL rx_order got %h exp %h", d, 32'h10 + i); end
    end
    load(CON, d);
    checks++; if (d !== 32'h41) begin errors++; $display("FAIL rx_drained_con got %h exp 41", d); end
    load(RXD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_load got %h exp 0", d); end
    store(CON, 32'h64);
  endtask

  task automatic test_simultaneous;
    for (int b = 'h20; b <= 'h23; b++) rx_byte(8'(b));
    rx_data = 8'h24; uart_signal[0] = 1; repeat (2) tick;
    load(RXD, d);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL simul_head got %h exp 20", d); end
    load(CON, d);
    checks++; if (d !== 32'h08) begin errors++; $display("FAIL simul_con got %h exp 08", d); end
    uart_signal[0] = 0; repeat (3) tick;
    for (int i = 1; i <= 4; i++) begin
      load(RXD, d);
      checks++; if (d !== 32'h20 + i) begin errors++; $display("FAIL simul_order got %h exp %h", d, 32'h20 + i); end
    end
    load(CON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL simul_end_con got %h exp 0", d); end
  endtask

  task automatic test_txovf_reset;
    store(TXD, 32'h55); store(TXD, 32'h66);
    checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL txovf_data got %h exp 55", tx_data); end
    load(CON, d);
    checks++; if (d !== 32'h30) begin errors++; $display("FAIL txovf_con got %h exp 30", d); end
    uart_signal[1] = 1; repeat (2) tick;
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL mid_hs tx_en %b exp 1", tx_en); end
    reset = 1; tick; reset = 0;
    checks++; if (tx_en !== 1'b0 || tx_data !== 8'h0) begin errors++; $display("FAIL rst_hs tx_en %b tx_data %h exp 0 00", tx_en, tx_data); end
    load(CON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_con got %h exp 0", d); end
    uart_signal[1] = 0; repeat (6) tick;
    store(CON, 32'h64);
    load(CON, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_clean_con got %h exp 0", d); end
  endtask

  task automatic test_window;
    store(BASE + 12, 32'hFFFF_FFFF);
    load(BASE + 12, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL window_rdata got %h exp 0", d); end
    load(CON, d);
    checks++; if (d !== 32'h0 || tx_en !== 1'b0) begin errors++; $display("FAIL window_state con %h tx_en %b exp 0 0", d, tx_en); end
    rx_byte(8'h77);
    bus.addr = RXD; bus.mem_rd = 1; bus.mem_wr = 1; tick; bus.mem_rd = 0; bus.mem_wr = 0;
    load(RXD, d);
    checks++; if (d !== 32'h77) begin errors++; $display("FAIL rdwr_ignored got %h exp 77", d); end
    load(RXD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rdwr_popped got %h exp 0", d); end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] b, mtx, e8;
    logic [31:0] w, exp_con;
    bit txie = 0, rxie = 0, txdone = 0, txovf = 0, rxovf = 0, ne;
    mtx = tx_data;
    repeat (60) begin
      case ($urandom_range(0, 4))
        0: begin
          b = 8'($urandom); store(TXD, {24'b0, b}); mtx = b;
          if ($urandom_range(0, 1) == 1) begin store(TXD, {24'b0, ~b}); txovf = 1; end
          tx_handshake; txdone = 1;
          checks++; if (tx_data !== mtx) begin errors++; $display("FAIL rnd_tx_data got %h exp %h", tx_data, mtx); end
        end
        1: begin
          w = $urandom; store(CON, w);
          txie = w[0]; rxie = w[1];
          if (w[2]) txdone = 0;
          if (w[5]) txovf = 0;
          if (w[6]) rxovf = 0;
        end
        2: begin
          e8 = q.size() != 0 ? q.pop_front() : 8'h0;
          load(RXD, d);
          checks++; if (d !== {24'b0, e8}) begin errors++; $display("FAIL rnd_rxd got %h exp %h", d, e8); end
        end
        3: begin
          b = 8'($urandom); rx_byte(b);
          if (q.size() < 4) q.push_back(b); else rxovf = 1;
        end
        default: tick;
      endcase
      tick;
      ne = q.size() != 0;
      exp_con = {25'b0, rxovf, txovf, 1'b0, ne, txdone, rxie, txie};
      load(CON, d);
      checks++; if (d !== exp_con) begin errors++; $display("FAIL rnd_con got %h exp %h", d, exp_con); end
      checks++; if (irq !== ((txie & txdone) | (rxie & ne))) begin errors++; $display("FAIL rnd_irq got %b exp %b", irq, (txie & txdone) | (rxie & ne)); end
    end
  endtask

  initial begin
    bus.addr = 0; bus.wdata = 0; bus.mem_wr = 0; bus.mem_rd = 0;
    test_reset;
    test_tx;
    test_irq;
    test_rx_overflow;
    test_simultaneous;
    test_txovf_reset;
    test_window;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
